lcd_init_seq: RTL
=================

LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 Parameter TIMER_CNT_1MS, default 27000: clk cycles per 1 ms tick (27 MHz clk).
REQ-002 Parameter NUM_CMDS, default 4: number of entries in the init command table.
REQ-003 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port resetn, input, 1: asynchronous, active-low reset.
REQ-005 Port hs_start, input, 1: power sequence complete, DSI HS clock running; level, held high while the panel is powered.
REQ-006 Port cmd_ready, input, 1: DSI packet generator accepts the presented command.
REQ-007 Port cmd_valid, output, 1: command presented.
REQ-008 Port cmd_dt, output, 6: DSI data type.
REQ-009 Port cmd_d0, output, 8: DCS opcode.
REQ-010 Port cmd_d1, output, 8: DCS parameter (0x00 when unused).
REQ-011 Port busy, output, 1: sequence in progress.
REQ-012 Port init_done, output, 1: all commands sent and all delays elapsed; gates the video path.

Function
REQ-013 Command table entries, in index order (dt, d0, d1, post-delay in ms):
- 0: 0x05, 0x11, 0x00, 120 (sleep out)
- 1: 0x15, 0x3A, 0x77, 0 (RGB888)
- 2: 0x15, 0x36, 0x00, 0
- 3: 0x05, 0x29, 0x00, 20 (display on)
REQ-014 FSM states and transitions:
- IDLE: entered from reset; go to LOAD on hs_start=1.
- LOAD: index = 0; go to SEND.
- SEND: drive entry[index], cmd_valid=1.
- WAIT: entered after acceptance.
- DELAY: count post-delay.
- DONE.
REQ-015 IDLE->LOAD occurs one cycle after hs_start is first sampled high; cmd_valid rises on the following cycle.
REQ-016 Handshake: a transfer occurs on an edge where cmd_valid=1 and cmd_ready=1. cmd_dt, cmd_d0 and cmd_d1 stay stable, and cmd_valid stays high, until that edge.
REQ-017 cmd_valid is 0 on the cycle after a transfer; there are no back-to-back commands (minimum 1-cycle gap).
REQ-018 After a transfer: if post-delay is 0, go to SEND for index+1. Otherwise go to DELAY, clear the timers, and remain until the 1 ms tick count equals the post-delay.
REQ-019 Timer: a 16-bit prescaler wraps at TIMER_CNT_1MS-1 and then increments a 10-bit ms counter. Both counters are cleared on every DELAY entry.
REQ-020 The measured delay is post-delay x TIMER_CNT_1MS cycles, +0/+2 cycles.
REQ-021 After entry NUM_CMDS-1 completes, including its delay, go to DONE. In DONE: init_done=1, busy=0, cmd_valid=0. Hold until hs_start falls.
REQ-022 busy=1 in LOAD, SEND, WAIT and DELAY; otherwise 0.
REQ-023 hs_start=0 sampled in any non-IDLE state: return to IDLE next cycle, cmd_valid=0, init_done=0, index and timers cleared. This abort overrides REQ-016.
REQ-024 If cmd_ready=1 and hs_start=0 arrive on the same edge, the abort wins and the transfer does not count.
REQ-025 cmd_ready while cmd_valid=0 is ignored.
REQ-026 A later rising edge of hs_start restarts from entry 0.

Reset
REQ-027 While resetn=0: state=IDLE, index=0, timers=0, cmd_valid=0, cmd_dt=0, cmd_d0=0, cmd_d1=0, busy=0, init_done=0.
REQ-028 Reset deassertion is synchronized externally; the block makes no other reset assumption.

Structure
REQ-029 A shared package lcd_pkg holds:
- state encodings;
- DSI data type constants: DT_DCS_SW0=0x05, DT_DCS_SW1=0x15;
- DCS opcodes.
REQ-030 The command table is a combinational sub-module, lcd_init_rom (index in; dt, d0, d1, delay out), sized by NUM_CMDS.
REQ-031 Index width is clog2(NUM_CMDS); indices at or above NUM_CMDS return all zeros.

Verification (bench TIMER_CNT_1MS=10)
REQ-032 Reset, hs_start=0 for 50 cycles -> cmd_valid=0, busy=0, init_done=0 throughout.
REQ-033 hs_start=1, cmd_ready tied 1 -> four transfers, (05,11,00), (15,3A,77), (15,36,00), (05,29,00), in that order.
- Gap between transfers 0 and 1: 1200 cycles +0/+2.
- init_done rises 200 cycles +0/+2 after transfer 3.
REQ-034 cmd_ready held 0 for 37 cycles during entry 1 -> cmd_valid and fields stable all 37 cycles; exactly one transfer recorded.
REQ-035 hs_start dropped 500 cycles into the 120 ms delay -> IDLE next cycle, busy=0.
- hs_start re-raised -> sequence restarts with 0x11.
REQ-036 resetn pulsed low mid-SEND (asynchronous, between edges) -> cmd_valid=0 immediately; all outputs at REQ-027 values.
REQ-037 cmd_ready=1 on the same edge hs_start falls -> no transfer counted; restart resends entry 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD panel init sequencer.
// Holds FSM encodings, DSI data types, DCS opcodes and widths.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DELAY = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int DT_W  = 6;
  localparam int B_W   = 8;
  localparam int MS_W  = 10;
  localparam int PRE_W = 16;

  localparam logic [DT_W-1:0] DT_DCS_SW0 = 6'h05;
  localparam logic [DT_W-1:0] DT_DCS_SW1 = 6'h15;

  localparam logic [B_W-1:0] DCS_SLPOUT = 8'h11;
  localparam logic [B_W-1:0] DCS_COLMOD = 8'h3A;
  localparam logic [B_W-1:0] DCS_MADCTL = 8'h36;
  localparam logic [B_W-1:0] DCS_DISPON = 8'h29;

  localparam logic [B_W-1:0] COLMOD_RGB888 = 8'h77;
  localparam logic [B_W-1:0] MADCTL_NORM   = 8'h00;
  localparam logic [B_W-1:0] PARAM_NONE    = 8'h00;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_init_seq_if.sv
// Command handshake bundle between the init sequencer and the
// DSI packet generator: valid/ready plus dt, d0, d1 fields.
interface lcd_init_seq_if;
  import lcd_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [DT_W-1:0] cmd_dt;
  logic [B_W-1:0]  cmd_d0;
  logic [B_W-1:0]  cmd_d1;

  modport master (
    output cmd_valid,
    output cmd_dt,
    output cmd_d0,
    output cmd_d1,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dt,
    input  cmd_d0,
    input  cmd_d1,
    output cmd_ready
  );

endinterface

// File: rtl/lcd_init_rom.sv
// Combinational init command table: idx_i -> dt, d0, d1, delay (ms).
// Indices at or above NUM_CMDS read back as all zeros.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int NUM_CMDS = 4,
  parameter int IW       = idx_w(NUM_CMDS)
) (
  input  logic [IW-1:0]   idx_i,
  output logic [DT_W-1:0] dt_o,
  output logic [B_W-1:0]  d0_o,
  output logic [B_W-1:0]  d1_o,
  output logic [MS_W-1:0] dly_o
);

  always_comb begin
    dt_o  = '0;
    d0_o  = '0;
    d1_o  = '0;
    dly_o = '0;
    if (int'(idx_i) < NUM_CMDS) begin
      case (int'(idx_i))
        0: begin
          dt_o  = DT_DCS_SW0;
          d0_o  = DCS_SLPOUT;
          d1_o  = PARAM_NONE;
          dly_o = 10'd120;
        end
        1: begin
          dt_o  = DT_DCS_SW1;
          d0_o  = DCS_COLMOD;
          d1_o  = COLMOD_RGB888;
          dly_o = 10'd0;
        end
        2: begin
          dt_o  = DT_DCS_SW1;
          d0_o  = DCS_MADCTL;
          d1_o  = MADCTL_NORM;
          dly_o = 10'd0;
        end
        3: begin
          dt_o  = DT_DCS_SW0;
          d0_o  = DCS_DISPON;
          d1_o  = PARAM_NONE;
          dly_o = 10'd20;
        end
        default: begin
          dt_o  = '0;
          d0_o  = '0;
          d1_o  = '0;
          dly_o = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_init_seq.sv
// Panel init sequencer: after hs_start, sends the ROM command table
// over a valid/ready port with ms post-delays, then flags init_done.
// Ports: clk, resetn, hs_start, cmd_ready in; cmd_valid, cmd_dt,
// cmd_d0, cmd_d1, busy, init_done out.
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int TIMER_CNT_1MS = 27000,
  parameter int NUM_CMDS      = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            hs_start,
  input  logic            cmd_ready,
  output logic            cmd_valid,
  output logic [DT_W-1:0] cmd_dt,
  output logic [B_W-1:0]  cmd_d0,
  output logic [B_W-1:0]  cmd_d1,
  output logic            busy,
  output logic            init_done
);

  localparam int IW = idx_w(NUM_CMDS);
  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(TIMER_CNT_1MS - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_CMDS - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [MS_W-1:0]   ms_q, ms_d;

  logic [DT_W-1:0]   rom_dt;
  logic [B_W-1:0]    rom_d0;
  logic [B_W-1:0]    rom_d1;
  logic [MS_W-1:0]   rom_dly;

  logic              tick;
  logic [MS_W-1:0]   ms_nxt;
  logic              adv;
  logic              send;

  lcd_init_rom #(
    .NUM_CMDS (NUM_CMDS),
    .IW       (IW)
  ) u_rom (
    .idx_i (idx_q),
    .dt_o  (rom_dt),
    .d0_o  (rom_d0),
    .d1_o  (rom_d1),
    .dly_o (rom_dly)
  );

  assign tick   = (pre_q == PRE_MAX);
  assign ms_nxt = ms_q + 10'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    adv     = 1'b0;
    // Dropping hs_start beats any pending handshake.
    if (state_q != ST_IDLE && !hs_start) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      pre_d   = '0;
      ms_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hs_start) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          idx_d   = '0;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (cmd_ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (rom_dly == '0) begin
            adv = 1'b1;
          end else begin
            state_d = ST_DELAY;
            pre_d   = '0;
            ms_d    = '0;
          end
        end
        ST_DELAY: begin
          // Leave on the tick that completes the last ms so the
          // next command is not held an extra cycle.
          if (tick) begin
            pre_d = '0;
            ms_d  = ms_nxt;
            adv   = (ms_nxt == rom_dly);
          end else begin
            pre_d = pre_q + 16'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (adv) begin
        if (idx_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_SEND;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
    end
  end

  assign send      = (state_q == ST_SEND);
  assign cmd_valid = send;
  assign cmd_dt    = send ? rom_dt : '0;
  assign cmd_d0    = send ? rom_d0 : '0;
  assign cmd_d1    = send ? rom_d1 : '0;
  assign busy      = (state_q == ST_LOAD)
                   | (state_q == ST_SEND)
                   | (state_q == ST_WAIT)
                   | (state_q == ST_DELAY);
  assign init_done = (state_q == ST_DONE);

endmodule
